// File: rtl/rbm_sched_pkg.sv
// Shared types and sizing helpers for the RBM Gibbs sweep scheduler.
package rbm_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  // Wide enough for UPDATE_LAT up to 15.
  localparam int LAT_W = 4;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gibbs_scheduler.sv
// Sequences hidden-then-visible node updates of an RBM for a requested number of
// Gibbs sweeps, driving an external sampling datapath one node at a time.
module gibbs_scheduler
  import rbm_sched_pkg::*;
#(
  parameter int NUM_VISIBLE = 3,
  parameter int NUM_HIDDEN  = 3,
  parameter int UPDATE_LAT  = 1,
  parameter int SWEEP_BITS  = 16,
  localparam int LAYER_W    = max_of(NUM_VISIBLE, NUM_HIDDEN),
  localparam int IDX_W      = idx_width(LAYER_W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [SWEEP_BITS-1:0]  num_sweeps,
  input  logic [NUM_VISIBLE-1:0] init_visible,
  input  logic [NUM_VISIBLE-1:0] clamp_mask,
  input  logic                   new_val,
  output logic                   layer,
  output logic [IDX_W-1:0]       node_idx,
  output logic [LAYER_W-1:0]     node_vec,
  output logic [NUM_VISIBLE-1:0] visible_state,
  output logic [NUM_HIDDEN-1:0]  hidden_state,
  output logic                   busy,
  output logic                   done
);

  state_t                 state, state_nxt;
  logic [LAT_W-1:0]       wait_cnt;
  logic [SWEEP_BITS-1:0]  sweeps_q;
  logic [SWEEP_BITS-1:0]  sweep_cnt;
  logic [NUM_VISIBLE-1:0] clamp_q;
  logic                   last_node;
  logic                   last_sweep;

  assign last_node  = layer ? (node_idx == IDX_W'(NUM_VISIBLE - 1))
                            : (node_idx == IDX_W'(NUM_HIDDEN - 1));
  // sweeps_q is never zero once a run is under way, so the subtraction cannot wrap.
  assign last_sweep = (sweep_cnt == (sweeps_q - SWEEP_BITS'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_sweeps == '0) ? DONE : ISSUE;
      // ISSUE is the first latency cycle, so WAIT only covers the remaining UPDATE_LAT-1.
      ISSUE:   state_nxt = (UPDATE_LAT > 1) ? WAIT : CAPTURE;
      WAIT:    if (wait_cnt == LAT_W'(UPDATE_LAT - 2)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (last_node && layer && last_sweep) ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    node_vec = '0;
    if (layer) node_vec[NUM_HIDDEN-1:0]  = hidden_state;
    else       node_vec[NUM_VISIBLE-1:0] = visible_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt      <= '0;
      sweeps_q      <= '0;
      sweep_cnt     <= '0;
      clamp_q       <= '0;
      layer         <= 1'b0;
      node_idx      <= '0;
      visible_state <= '0;
      hidden_state  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (start) begin
            visible_state <= init_visible;
            clamp_q       <= clamp_mask;
            sweeps_q      <= num_sweeps;
            sweep_cnt     <= '0;
            layer         <= 1'b0;
            node_idx      <= '0;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT:  wait_cnt <= wait_cnt + LAT_W'(1);
        CAPTURE: begin
          for (int unsigned i = 0; i < NUM_HIDDEN; i++) begin
            if (!layer && node_idx == IDX_W'(i)) hidden_state[i] <= new_val;
          end
          for (int unsigned i = 0; i < NUM_VISIBLE; i++) begin
            if (layer && node_idx == IDX_W'(i) && !clamp_q[i]) visible_state[i] <= new_val;
          end
          if (last_node) begin
            node_idx <= '0;
            layer    <= ~layer;
            if (layer) sweep_cnt <= sweep_cnt + SWEEP_BITS'(1);
          end else begin
            node_idx <= node_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
